pll_supervisor: RTL and testbench

Parametrised PLL supervisor and reset sequencer that sits beside a vendor PLL primitive.
- Drives the PLL reset and filters its asynchronous lock output.
- Retries acquisition on timeout, with a bounded retry count.
- Holds and stretches the system reset until the clock is trusted.
- Reports lock loss and failure status.
- Runs on the PLL reference clock, so it stays alive while the PLL output is absent.

---
 rtl/pll_supervisor.sv | 164 ++++++++++++++++
 tb/tb_pll_supervisor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_supervisor.sv
// PLL supervisor and reset sequencer running on the PLL reference clock.
// Drives the PLL reset, qualifies its lock output, retries acquisition and stretches sys_rst.
`timescale 1ns/1ps

module pll_supervisor #(
    parameter int PLL_RESET_CYCLES    = 16,
    parameter int LOCK_FILTER_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int RST_STRETCH_CYCLES  = 256,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_WIDTH           = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pll_lock,
    input  logic                 force_relock,
    input  logic                 clear_counts,
    output logic                 pll_reset,
    output logic                 sys_rst,
    output logic                 locked,
    output logic                 fail,
    output logic [CNT_WIDTH-1:0] retry_count,
    output logic [CNT_WIDTH-1:0] loss_count
);

    localparam logic [2:0] PLL_RST   = 3'd0;
    localparam logic [2:0] WAIT_LOCK = 3'd1;
    localparam logic [2:0] FILTER    = 3'd2;
    localparam logic [2:0] STRETCH   = 3'd3;
    localparam logic [2:0] RUN       = 3'd4;
    localparam logic [2:0] FAILED    = 3'd5;

    localparam int MAX_AB  = (PLL_RESET_CYCLES > LOCK_FILTER_CYCLES) ? PLL_RESET_CYCLES : LOCK_FILTER_CYCLES;
    localparam int MAX_CD  = (LOCK_TIMEOUT_CYCLES > RST_STRETCH_CYCLES) ? LOCK_TIMEOUT_CYCLES : RST_STRETCH_CYCLES;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] RESET_LAST   = TW'(PLL_RESET_CYCLES - 1);
    localparam logic [TW-1:0] FILTER_LAST  = TW'(LOCK_FILTER_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] STRETCH_LAST = TW'(RST_STRETCH_CYCLES - 1);
    localparam int unsigned   MAX_R        = MAX_RETRIES;

    logic                 lock_meta;
    logic                 lock_s;
    logic [2:0]           state;
    logic [2:0]           next_state;
    logic [TW-1:0]        timer;
    logic                 timer_clr;
    logic                 retry_inc;
    logic                 retry_clr;
    logic                 loss_inc;
    logic [CNT_WIDTH-1:0] retry_plus;

    // pll_lock comes from the PLL output domain, so it is only used after two flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    assign retry_plus = (retry_count == '1) ? retry_count : retry_count + 1'b1;

    always_comb begin
        next_state = state;
        retry_inc  = 1'b0;
        retry_clr  = 1'b0;
        loss_inc   = 1'b0;
        if (force_relock) begin
            next_state = PLL_RST;
            retry_clr  = 1'b1;
        end else begin
            case (state)
                PLL_RST: begin
                    if (timer == RESET_LAST) next_state = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        next_state = FILTER;
                    end else if (timer == TIMEOUT_LAST) begin
                        retry_inc = 1'b1;
                        if ((MAX_R != 0) && (32'(retry_plus) >= MAX_R)) next_state = FAILED;
                        else next_state = PLL_RST;
                    end
                end
                FILTER: begin
                    if (!lock_s) next_state = WAIT_LOCK;
                    else if (timer == FILTER_LAST) next_state = STRETCH;
                end
                STRETCH: begin
                    if (!lock_s) next_state = PLL_RST;
                    else if (timer == STRETCH_LAST) next_state = RUN;
                end
                RUN: begin
                    if (!lock_s) begin
                        next_state = PLL_RST;
                        loss_inc   = 1'b1;
                        retry_clr  = 1'b1;
                    end
                end
                FAILED: begin
                    next_state = FAILED;
                end
                default: begin
                    next_state = PLL_RST;
                end
            endcase
        end
    end

    // A relock request re-enters PLL_RST even from PLL_RST, so it also restarts the timer.
    assign timer_clr = force_relock || (next_state != state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PLL_RST;
            timer <= '0;
        end else begin
            state <= next_state;
            if (timer_clr) timer <= '0;
            else if (timer != '1) timer <= timer + 1'b1;
        end
    end

    // Outputs decode next_state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pll_reset <= 1'b1;
            sys_rst   <= 1'b1;
            locked    <= 1'b0;
            fail      <= 1'b0;
        end else begin
            pll_reset <= (next_state == PLL_RST) || (next_state == FAILED);
            sys_rst   <= (next_state != RUN);
            locked    <= (next_state == RUN);
            fail      <= (next_state == FAILED);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_count <= '0;
        end else if (retry_clr) begin
            retry_count <= '0;
        end else if (retry_inc) begin
            retry_count <= retry_plus;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loss_count <= '0;
        end else if (clear_counts) begin
            loss_count <= '0;
        end else if (loss_inc && (loss_count != '1)) begin
            loss_count <= loss_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed bench for pll_supervisor with small parameters and hand-computed cycle counts.
`timescale 1ns/1ps

module tb_pll_supervisor;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          pll_lock;
  logic          force_relock;
  logic          clear_counts;
  logic          pll_reset;
  logic          sys_rst;
  logic          locked;
  logic          fail;
  logic [CW-1:0] retry_count;
  logic [CW-1:0] loss_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pll_supervisor #(
    .PLL_RESET_CYCLES   (4),
    .LOCK_FILTER_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .RST_STRETCH_CYCLES (4),
    .MAX_RETRIES        (2),
    .CNT_WIDTH          (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pll_lock    (pll_lock),
    .force_relock(force_relock),
    .clear_counts(clear_counts),
    .pll_reset   (pll_reset),
    .sys_rst     (sys_rst),
    .locked      (locked),
    .fail        (fail),
    .retry_count (retry_count),
    .loss_count  (loss_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Number of consecutive samples (including the current one) with pll_reset at level.
  task automatic measure_pll_reset(input logic level, output int n);
    n = 0;
    while ((pll_reset === level) && (n < 200)) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_sys_rst_low(output int n);
    n = 0;
    while ((sys_rst !== 1'b0) && (n < 300)) begin
      tick();
      n++;
    end
  endtask

  // Drop lock for three cycles while in RUN, optionally pulsing clear_counts on the loss edge.
  task automatic lose_lock(input logic with_clear);
    int n;
    pll_lock = 1'b0;
    tick();
    tick();
    clear_counts = with_clear;
    tick();
    clear_counts = 1'b0;
    check_eq("loss_sys_rst", sys_rst, 1'b1);
    pll_lock = 1'b1;
    wait_sys_rst_low(n);
    check_eq("reacq_len", n, 17);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst          = 1'b1;
    pll_lock     = 1'b0;
    force_relock = 1'b0;
    clear_counts = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_pll_reset", pll_reset, 1'b1);
    check_eq("rst_sys_rst", sys_rst, 1'b1);
    check_eq("rst_locked", locked, 1'b0);
    check_eq("rst_fail", fail, 1'b0);
    check_eq("rst_retry", retry_count, 0);
    check_eq("rst_loss", loss_count, 0);

    // 1: clean lock
    rst = 1'b0;
    measure_pll_reset(1'b1, n);
    check_eq("t1_pll_reset_len", n, 4);
    pll_lock = 1'b1;
    wait_sys_rst_low(n);
    check_eq("t1_sys_rst_latency", n, 15);
    check_eq("t1_locked", locked, 1'b1);
    check_eq("t1_retry", retry_count, 0);
    check_eq("t1_pll_reset", pll_reset, 1'b0);
    check_eq("t1_fail", fail, 1'b0);

    // 2: glitchy lock during FILTER
    force_relock = 1'b1;
    pll_lock     = 1'b0;
    tick();
    force_relock = 1'b0;
    check_eq("t2_locked_after_force", locked, 1'b0);
    measure_pll_reset(1'b1, n);
    check_eq("t2_pll_reset_len", n, 4);
    pll_lock = 1'b1;
    repeat (5) tick();
    pll_lock = 1'b0;
    repeat (4) tick();
    check_eq("t2_sys_rst_held", sys_rst, 1'b1);
    check_eq("t2_retry", retry_count, 0);
    pll_lock = 1'b1;
    wait_sys_rst_low(n);
    check_eq("t2_sys_rst_latency", n, 15);
    check_eq("t2_locked", locked, 1'b1);

    // 3: timeout, retries, FAILED, force_relock
    force_relock = 1'b1;
    pll_lock     = 1'b0;
    tick();
    force_relock = 1'b0;
    measure_pll_reset(1'b1, n);
    check_eq("t3_pulse1_len", n, 4);
    check_eq("t3_retry0", retry_count, 0);
    measure_pll_reset(1'b0, n);
    check_eq("t3_wait1_len", n, 32);
    check_eq("t3_retry1", retry_count, 1);
    check_eq("t3_fail_early", fail, 1'b0);
    measure_pll_reset(1'b1, n);
    check_eq("t3_pulse2_len", n, 4);
    measure_pll_reset(1'b0, n);
    check_eq("t3_wait2_len", n, 32);
    check_eq("t3_retry2", retry_count, 2);
    check_eq("t3_fail", fail, 1'b1);
    check_eq("t3_failed_pll_reset", pll_reset, 1'b1);
    check_eq("t3_failed_sys_rst", sys_rst, 1'b1);
    check_eq("t3_failed_locked", locked, 1'b0);
    pll_lock = 1'b1;
    repeat (10) tick();
    check_eq("t3_fail_sticky", fail, 1'b1);
    check_eq("t3_pll_reset_sticky", pll_reset, 1'b1);
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    check_eq("t3_relock_fail", fail, 1'b0);
    check_eq("t3_relock_retry", retry_count, 0);
    check_eq("t3_relock_pll_reset", pll_reset, 1'b1);
    wait_sys_rst_low(n);
    check_eq("t3_reacq_len", n, 17);

    // 4: loss in RUN
    pll_lock = 1'b0;
    tick();
    tick();
    check_eq("t4_sys_rst_before", sys_rst, 1'b0);
    check_eq("t4_locked_before", locked, 1'b1);
    tick();
    check_eq("t4_sys_rst_after", sys_rst, 1'b1);
    check_eq("t4_locked_after", locked, 1'b0);
    check_eq("t4_loss", loss_count, 1);
    check_eq("t4_retry", retry_count, 0);
    pll_lock = 1'b1;
    wait_sys_rst_low(n);
    check_eq("t4_reacq_len", n, 17);

    // 5: saturation and clear priority
    repeat (14) lose_lock(1'b0);
    check_eq("t5_loss15", loss_count, 15);
    repeat (2) lose_lock(1'b0);
    check_eq("t5_loss_sat", loss_count, 15);
    lose_lock(1'b1);
    check_eq("t5_loss_clear", loss_count, 0);

    // 6: force_relock beats lock loss; async rst mid-STRETCH
    lose_lock(1'b0);
    check_eq("t6_loss_pre", loss_count, 1);
    pll_lock = 1'b0;
    tick();
    tick();
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    check_eq("t6_loss_unchanged", loss_count, 1);
    check_eq("t6_pll_reset", pll_reset, 1'b1);
    check_eq("t6_locked", locked, 1'b0);
    pll_lock = 1'b1;
    repeat (14) tick();
    check_eq("t6_in_stretch", sys_rst, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_pll_reset", pll_reset, 1'b1);
    check_eq("t6_rst_sys_rst", sys_rst, 1'b1);
    check_eq("t6_rst_locked", locked, 1'b0);
    check_eq("t6_rst_fail", fail, 1'b0);
    check_eq("t6_rst_retry", retry_count, 0);
    check_eq("t6_rst_loss", loss_count, 0);
    tick();
    rst      = 1'b0;
    pll_lock = 1'b0;
    measure_pll_reset(1'b1, n);
    check_eq("t6_restart_pulse", n, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
